// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: FSM state encoding, default widths
// and the MEM/WB field bundle.
package mem_stage_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int RD_W_DEF   = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic                  regwrite;
      logic                  memtoreg;
      logic [DATA_W_DEF-1:0] rdata;
      logic [DATA_W_DEF-1:0] out;
      logic [RD_W_DEF-1:0]   rd;
   } mem_wb_t;

   function automatic logic is_mem_op(input logic memread, input logic memwrite);
      return memread | memwrite;
   endfunction

endpackage

// File: rtl/mem_bypass_buf.sv
// One-entry store buffer with address-hit compare, used when MEM_BYPASS_EN is defined.
module mem_bypass_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              hit,
   output logic [DATA_W-1:0] rd_data
);

   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (wr_en) begin
         valid_q <= 1'b1;
         addr_q  <= wr_addr;
         data_q  <= wr_data;
      end
   end

   assign hit     = valid_q && (addr_q == rd_addr);
   assign rd_data = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack port, stalls
// upstream while waiting, registers MEM/WB fields. Optional feature: MEM_BYPASS_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RD_W   = RD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_regwrite,
   input  logic              MEM_memtoreg,
   input  logic              MEM_memread,
   input  logic              MEM_memwrite,
   input  logic [DATA_W-1:0] MEM_out,
   input  logic [DATA_W-1:0] MEM_wdata,
   input  logic [RD_W-1:0]   MEM_rd,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              WB_regwrite,
   output logic              WB_memtoreg,
   output logic [DATA_W-1:0] WB_rdata,
   output logic [DATA_W-1:0] WB_out,
   output logic [RD_W-1:0]   WB_rd,
   output mem_state_e        dbg_state
);

   // Memory handshake: dmem_req is high for the whole WAIT state and the
   // dmem_we/addr/wdata copies stay constant until the cycle dmem_ack pulses;
   // that ack cycle is the only cycle in which dmem_rdata is consumed.

   typedef struct packed {
      logic              regwrite;
      logic              memtoreg;
      logic [DATA_W-1:0] rdata;
      logic [DATA_W-1:0] out;
      logic [RD_W-1:0]   rd;
   } wb_fields_t;

   mem_state_e        state;
   wb_fields_t        wb_q;
   logic              mem_op;
   logic              start;
   logic              bp_hit;
   logic [DATA_W-1:0] bp_data;

   assign mem_op = is_mem_op(MEM_memread, MEM_memwrite);

`ifdef MEM_BYPASS_EN
   logic buf_hit;
   logic buf_wr;

   assign buf_wr = (state == ST_WAIT) && dmem_ack && dmem_we;

   mem_bypass_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_bypass_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_wr),
      .wr_addr (dmem_addr),
      .wr_data (dmem_wdata),
      .rd_addr (MEM_out[ADDR_W-1:0]),
      .hit     (buf_hit),
      .rd_data (bp_data)
   );

   // A load with write also set is a store, so it never takes the bypass.
   assign bp_hit = MEM_memread & ~MEM_memwrite & buf_hit;
`else
   assign bp_hit  = 1'b0;
   assign bp_data = '0;
`endif

   assign start    = (state == ST_IDLE) && mem_op && !bp_hit;
   assign dmem_req = (state == ST_WAIT);

   always_comb begin
      mem_stall = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: mem_stall = start;
            ST_WAIT: mem_stall = ~dmem_ack;
            default: mem_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_q       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  dmem_we       <= MEM_memwrite;
                  dmem_addr     <= MEM_out[ADDR_W-1:0];
                  dmem_wdata    <= MEM_wdata;
                  wb_q.regwrite <= 1'b0;
                  wb_q.memtoreg <= 1'b0;
                  state         <= ST_WAIT;
               end else begin
                  wb_q.regwrite <= MEM_regwrite;
                  wb_q.memtoreg <= MEM_memtoreg;
                  wb_q.out      <= MEM_out;
                  wb_q.rd       <= MEM_rd;
                  if (bp_hit) begin
                     wb_q.rdata <= bp_data;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  // EX/MEM fields are still held upstream, so they are used directly.
                  wb_q.regwrite <= MEM_regwrite;
                  wb_q.memtoreg <= MEM_memtoreg;
                  wb_q.out      <= MEM_out;
                  wb_q.rd       <= MEM_rd;
                  if (!dmem_we) begin
                     wb_q.rdata <= dmem_rdata;
                  end
                  state <= ST_IDLE;
               end else begin
                  wb_q.regwrite <= 1'b0;
                  wb_q.memtoreg <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign WB_regwrite = wb_q.regwrite;
   assign WB_memtoreg = wb_q.memtoreg;
   assign WB_rdata    = wb_q.rdata;
   assign WB_out      = wb_q.out;
   assign WB_rd       = wb_q.rd;
   assign dbg_state   = state;

endmodule
